// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mole_round_ctrl
// Description : Whack-a-mole round controller. Draws a mole index from the
//               PRNG, lights one of eight moles, scores button presses
//               against the lit mole and ends the game after MAX_MISS misses.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_round_ctrl #(
  parameter int GAP_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_MISS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rnd,
  input  logic [7:0] btn,
  output logic       rnd_take,
  output logic [7:0] mole,
  output logic [7:0] score,
  output logic [3:0] miss,
  output logic       busy,
  output logic       game_over
);

  localparam int c_MAX_CNT = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES);
  localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_TWO   = c_CNT_W'(2);
  localparam logic [3:0]         c_MISS_END  = 4'(MAX_MISS);
  // A one-cycle gap means the very first GAP cycle is also the draw cycle.
  localparam logic               c_GAP_IS_1  = (GAP_CYCLES == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_SHOW = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_last_idx;
  logic                 r_first;
  logic [7:0]           r_btn_q;

  logic [7:0]           w_rise;
  logic [2:0]           w_idx;
  logic                 w_hit;
  logic                 w_miss_evt;
  logic [3:0]           w_miss_inc;
  logic                 w_unused_rnd;

  // Only the low three PRNG bits select a mole.
  assign w_unused_rnd = &{1'b0, rnd[7:3]};

  // Edge detect on buttons, mole draw with repeat avoidance, miss classification.
  always_comb begin
    w_rise     = btn & ~r_btn_q;
    w_idx      = rnd[2:0];
    if (!r_first && (rnd[2:0] == r_last_idx)) begin
      w_idx = rnd[2:0] + 3'd1;
    end
    // mole holds one-hot(idx) throughout SHOW, so it is the hit pattern.
    w_hit      = (w_rise == mole);
    w_miss_evt = (w_rise != 8'd0) || (r_cnt == c_CNT_ONE);
    w_miss_inc = miss + 4'd1;
  end

  // Round state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last_idx <= 3'd0;
      r_first    <= 1'b0;
      r_btn_q    <= 8'hFF;
      rnd_take   <= 1'b0;
      mole       <= 8'd0;
      score      <= 8'd0;
      miss       <= 4'd0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      r_btn_q  <= btn;
      rnd_take <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            score     <= 8'd0;
            miss      <= 4'd0;
            r_cnt     <= c_GAP_LOAD;
            r_first   <= 1'b1;
            busy      <= 1'b1;
            game_over <= 1'b0;
            rnd_take  <= c_GAP_IS_1;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt == c_CNT_ONE) begin
            r_last_idx <= w_idx;
            mole       <= 8'd1 << w_idx;
            r_cnt      <= c_HOLD_LOAD;
            r_first    <= 1'b0;
            r_state    <= S_SHOW;
          end else begin
            r_cnt    <= r_cnt - c_CNT_ONE;
            // Raise the PRNG strobe for the final GAP cycle.
            rnd_take <= (r_cnt == c_CNT_TWO);
          end
        end
        S_SHOW: begin
          if (w_hit) begin
            if (score != 8'hFF) begin
              score <= score + 8'd1;
            end
            mole     <= 8'd0;
            r_cnt    <= c_GAP_LOAD;
            rnd_take <= c_GAP_IS_1;
            r_state  <= S_GAP;
          end else if (w_miss_evt) begin
            miss  <= w_miss_inc;
            mole  <= 8'd0;
            r_cnt <= c_GAP_LOAD;
            if (w_miss_inc == c_MISS_END) begin
              busy      <= 1'b0;
              game_over <= 1'b1;
              r_state   <= S_OVER;
            end else begin
              rnd_take <= c_GAP_IS_1;
              r_state  <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_round_ctrl
// Description : Directed self-checking bench for mole_round_ctrl with
//               hand-computed expected values (GAP=4, HOLD=8, MAX_MISS=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_round_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] rnd;
  logic [7:0] btn;
  logic       rnd_take;
  logic [7:0] mole;
  logic [7:0] score;
  logic [3:0] miss;
  logic       busy;
  logic       game_over;

  int n_total = 0;
  int n_bad   = 0;

  mole_round_ctrl #(
    .GAP_CYCLES (4),
    .HOLD_CYCLES(8),
    .MAX_MISS   (3)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rnd      (rnd),
    .btn      (btn),
    .rnd_take (rnd_take),
    .mole     (mole),
    .score    (score),
    .miss     (miss),
    .busy     (busy),
    .game_over(game_over)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // {mole, score, miss, busy, game_over, rnd_take} packed for one-shot checks.
  function automatic logic [31:0] outs();
    return {9'd0, mole, score, miss, busy, game_over, rnd_take};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; rnd = 8'h00; btn = 8'h00;
    tick(3);
    rst = 1'b0;
    chk("reset_outs", outs(), 32'd0);
    tick(2);

    // ---- game 1: hit, repeat avoidance, wrong presses, final timeout ----
    rnd = 8'h05; start = 1'b1;
    tick(1); start = 1'b0;                        // E0
    chk("e0_busy", busy, 1);
    chk("e0_take", rnd_take, 0);
    tick(2);                                      // E2
    chk("gap3_take", rnd_take, 0);
    tick(1);                                      // E3: last GAP cycle
    chk("gap4_take", rnd_take, 1);
    chk("gap4_mole", mole, 8'h00);
    tick(1);                                      // E4: SHOW cycle 1
    chk("show1_mole", mole, 8'h20);
    chk("show1_take", rnd_take, 0);
    tick(2);                                      // E6: SHOW cycle 3
    chk("show3_mole", mole, 8'h20);
    btn = 8'h20;
    tick(1);                                      // E7: hit
    btn = 8'h00;
    chk("hit_score", score, 1);
    chk("hit_mole", mole, 8'h00);
    chk("hit_miss", miss, 0);
    chk("hit_busy", busy, 1);
    tick(2);                                      // E9
    chk("hit_gap3_take", rnd_take, 0);
    tick(1);                                      // E10
    chk("hit_gap4_take", rnd_take, 1);
    tick(1);                                      // E11: repeat idx 5 -> 6
    chk("repeat5_mole", mole, 8'h40);
    btn = 8'h01;
    tick(1);                                      // E12: wrong press
    btn = 8'h00; rnd = 8'h07;
    chk("wrong_miss", miss, 1);
    chk("wrong_mole", mole, 8'h00);
    chk("wrong_score", score, 1);
    tick(4);                                      // E16
    chk("rnd7_mole", mole, 8'h80);
    btn = 8'h81;
    tick(1);                                      // E17: correct + extra
    btn = 8'h00;
    chk("multi_miss", miss, 2);
    chk("multi_score", score, 1);
    chk("multi_mole", mole, 8'h00);
    tick(4);                                      // E21: repeat idx 7 -> 0
    chk("repeat7_mole", mole, 8'h01);
    tick(7);                                      // E28: SHOW cycle 8
    chk("to_last_mole", mole, 8'h01);
    chk("to_last_miss", miss, 2);
    tick(1);                                      // E29: third miss
    chk("over_mole", mole, 8'h00);
    chk("over_miss", miss, 3);
    chk("over_flag", game_over, 1);
    chk("over_busy", busy, 0);
    chk("over_score", score, 1);
    tick(3);
    chk("over_take", rnd_take, 0);
    chk("over_hold", game_over, 1);

    // ---- game 2: restart from OVER, three timeouts ----
    rnd = 8'h05; start = 1'b1;
    tick(1); start = 1'b0;                        // F0
    chk("restart_score", score, 0);
    chk("restart_miss", miss, 0);
    chk("restart_busy", busy, 1);
    chk("restart_over", game_over, 0);
    tick(1); start = 1'b1;                        // start during GAP is ignored
    tick(1); start = 1'b0;
    tick(2);                                      // F4
    chk("g2r1_mole", mole, 8'h20);
    tick(7);                                      // F11
    chk("g2r1_mole_c8", mole, 8'h20);
    tick(1);                                      // F12
    chk("g2r1_to_mole", mole, 8'h00);
    chk("g2r1_to_miss", miss, 1);
    chk("g2r1_to_busy", busy, 1);
    tick(4);                                      // F16
    chk("g2r2_mole", mole, 8'h40);
    tick(8);                                      // F24
    chk("g2r2_miss", miss, 2);
    tick(4);                                      // F28
    chk("g2r3_mole", mole, 8'h20);
    tick(8);                                      // F36
    chk("g2_over_outs", outs(), {9'd0, 8'h00, 8'd0, 4'd3, 1'b0, 1'b1, 1'b0});

    // ---- game 3: asynchronous reset mid-SHOW, held button ----
    start = 1'b1;
    tick(1); start = 1'b0;                        // G0
    tick(4);                                      // G4
    chk("g3_mole", mole, 8'h20);
    tick(1);
    btn = 8'h20;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", outs(), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    start = 1'b1; rnd = 8'h05;
    tick(1); start = 1'b0;                        // H0
    tick(4);                                      // H4
    chk("held_mole", mole, 8'h20);
    tick(8);                                      // H12
    chk("held_score", score, 0);
    chk("held_miss", miss, 1);
    chk("held_mole_clr", mole, 8'h00);

    // ---- game 4: score saturation over 260 hits ----
    btn = 8'h00;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    start = 1'b1;
    tick(1); start = 1'b0;
    for (int i = 0; i < 260; i++) begin
      rnd = 8'(i * 37);
      for (int k = 0; k < 20 && mole == 8'h00; k++) tick(1);
      if (mole == 8'h00) begin
        chk("sat_wait", 32'd0, 32'd1);
        break;
      end
      btn = mole;
      tick(1);
      btn = 8'h00;
      if (i == 0)   chk("sat_first", score, 1);
      if (i == 254) chk("sat_255", score, 255);
    end
    chk("sat_final", score, 255);
    chk("sat_miss", miss, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
